uart_inst_loader: RTL and testbench
===================================

Name: uart_inst_loader

Overview:
- Receive-side counterpart of the bench-driven UART instruction stream.
- Deserialises 8N1 UART frames on `rx_i`, LSB first, and packs every 4 bytes little-endian into a 32-bit word.
- Issues each word as a write request with incrementing address toward ICCM over a valid/grant handshake.
- Sits between the `uart_rx_inst` pad and the instruction-memory write port; active while `sel` (`en_i`) is high, ahead of core reset release.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud, rounded up).
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- END_WORD, 32'h0000_0FFF, terminator word; ends the load and is never written.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  loader enable (`sel`).
- rx_i  in  1  serial input, idle high.
- we_o  out  1  write request valid.
- addr_o  out  32  write byte address.
- wdata_o  out  32  write data.
- gnt_i  in  1  write accepted (sampled at posedge while `we_o`=1).
- done_o  out  1  sticky; END_WORD received.
- frame_err_o  out  1  sticky; stop bit sampled low.
- overrun_o  out  1  sticky; word completed while previous write still pending.
- word_cnt_o  out  16  number of words accepted.

Behaviour:
- Reset: `we_o`=0, `addr_o`=BASE_ADDR, `wdata_o`=0, `done_o`=0, `frame_err_o`=0, `overrun_o`=0, `word_cnt_o`=0. FSM in IDLE, byte index 0, synchroniser flops =1.
- `rx_i` passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Moves to START on a synchronised high-to-low transition, only if `en_i`=1 and `done_o`=0.
  - A line held low without a preceding high never triggers.
- START: counts CLKS_PER_BIT/2 (integer divide), then samples the line.
  - Sample 0: go to DATA, counter reset.
  - Sample 1: glitch; return to IDLE, nothing recorded.
- DATA: samples the line every CLKS_PER_BIT cycles (mid-bit). Bit k of 8 goes to byte bit k. After bit 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, samples the line.
  - Sample 1: byte is valid and stored in lane [8*idx+7 : 8*idx]; idx increments modulo 4.
  - Sample 0: `frame_err_o` is set, the byte is discarded and idx is unchanged.
  - Either way the FSM returns to IDLE.
- Word completion (idx wraps 3→0):
  - Word == END_WORD: `done_o`=1 on the next cycle, no write; all further frames ignored until reset.
  - Otherwise, if `we_o`=0: next cycle `we_o`=1, `wdata_o`=word, `addr_o`=BASE_ADDR + 4*`word_cnt_o`.
  - Otherwise (`we_o` still 1): the new word is dropped and `overrun_o` is set.
- Handshake:
  - `we_o`, `addr_o` and `wdata_o` hold stable until a posedge with `gnt_i`=1.
  - That same edge clears `we_o` and increments `word_cnt_o`, so `addr_o` advances by 4 for the next word.
  - `gnt_i` is ignored while `we_o`=0.
  - `word_cnt_o` wraps at 16'hFFFF→0.
- Latency: `we_o` rises exactly 1 clk after the stop-bit sample edge of the 4th byte.
- `en_i` low:
  - FSM is forced to IDLE, counters are cleared and partial byte index is reset to 0.
  - A pending write still completes; sticky flags and `word_cnt_o` are kept.
- Reset mid-frame or mid-write: everything returns to reset values immediately (async). No write survives reset.
- Simultaneous grant and new word completion on the same edge: the grant retires the old word, the new word is presented on the next cycle, and no overrun is flagged.

Test Plan (CLKS_PER_BIT=16 for speed):
- Bytes 13,01,20,00 -> one write: `wdata_o`=32'h00200113, `addr_o`=0x0, `we_o` 1 clk after 4th stop sample; `gnt_i` 1 -> `word_cnt_o`=1.
- Three words 0x00000093, 0x00100113, 0x00208193 with `gnt_i` tied 1 -> addresses 0x0, 0x4, 0x8 in order; `word_cnt_o`=3.
- Word bytes FF,0F,00,00 after two data words -> `done_o`=1, no `we_o` pulse, `word_cnt_o`=2; a following frame produces no write.
- Frame with stop bit 0 in byte 2 -> `frame_err_o`=1, that byte dropped; the next 3 good bytes complete the word; data equals bytes 1,3,4,5.
- Low pulse of 4 clks on an idle line -> no byte recorded, FSM back in IDLE, no flags.
- `gnt_i` held 0 through a second word -> `overrun_o`=1, first word still presented unchanged. Then assert `rst_ni`=0 mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/uart_inst_loader.sv
// uart_inst_loader: 8N1 UART receiver packing 4 bytes little-endian into words written to ICCM over valid/grant.
module uart_inst_loader #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        rx_i,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  output logic        done_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic [15:0] word_cnt_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic          wv_q, wv_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          fall;

  assign fall = rx_prev_q & ~rx_sync_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    word_d  = word_q;
    wv_d    = 1'b0;
    we_d    = we_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (fall && en_i && !done_q) state_d = START;
      end
      START: begin
        cnt_d = (cnt_q == HALF) ? '0 : cnt_q + 1'b1;
        if (cnt_q == HALF) state_d = rx_sync_q ? IDLE : DATA;
      end
      DATA: begin
        cnt_d = (cnt_q == FULL) ? '0 : cnt_q + 1'b1;
        if (cnt_q == FULL) begin
          byte_d[bit_q] = rx_sync_q;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = (cnt_q == FULL) ? '0 : cnt_q + 1'b1;
        if (cnt_q == FULL) begin
          state_d = IDLE;
          if (rx_sync_q) begin
            word_d[8*idx_q +: 8] = byte_q;
            idx_d = idx_q + 2'd1;
            wv_d  = (idx_q == 2'd3);
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      idx_d   = '0;
      wv_d    = 1'b0;
    end
    if (we_q && gnt_i) begin
      we_d   = 1'b0;
      wcnt_d = wcnt_q + 16'd1;
    end
    // a grant on the completion edge frees the slot, so the new word is taken instead of dropped
    if (wv_q) begin
      if (word_q == END_WORD) done_d = 1'b1;
      else if (we_q && !gnt_i) ovr_d = 1'b1;
      else begin
        we_d    = 1'b1;
        wdata_d = word_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      wv_q      <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wcnt_q    <= '0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      wv_q      <= wv_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      wcnt_q    <= wcnt_d;
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign we_o        = we_q;
  assign wdata_o     = wdata_q;
  assign addr_o      = BASE_ADDR + {14'd0, wcnt_q, 2'b00};
  assign done_o      = done_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign word_cnt_o  = wcnt_q;
endmodule

// File: tb/tb_uart_inst_loader.sv
// tb_uart_inst_loader: scoreboard bench driving UART frames into uart_inst_loader.
module tb_uart_inst_loader;
  localparam int CPB = 16;
  // start drive -> 2 sync flops + edge detect + half bit + 8 data bits + stop bit, then one more clk
  localparam int LAT = 3 + CPB / 2 + 9 * CPB + 1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b1;
  logic        rx_i = 1'b1;
  logic        gnt_i = 1'b0;
  logic        we_o, done_o, frame_err_o, overrun_o;
  logic [31:0] addr_o, wdata_o;
  logic [15:0] word_cnt_o;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rise_cyc = -1;
  int          wr_idx = 0;
  logic        we_prev = 1'b0;
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];

  uart_inst_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .rx_i(rx_i),
    .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .gnt_i(gnt_i),
    .done_o(done_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
    .word_cnt_o(word_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic run_monitor;
    logic [31:0] d, a;
    forever begin
      @(negedge clk_i);
      if (we_o && !we_prev) rise_cyc = cyc;
      we_prev = we_o;
      if (rst_ni && we_o && gnt_i) begin
        checks++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%h data=%h, required no write", addr_o, wdata_o);
        end else begin
          d = exp_data.pop_front();
          a = exp_addr.pop_front();
          if (wdata_o !== d || addr_o !== a) begin
            errors++;
            $display("FAIL write: addr=%h data=%h, required addr=%h data=%h", addr_o, wdata_o, a, d);
          end
        end
      end
    end
  endtask

  task automatic expect_write(input logic [31:0] w);
    exp_data.push_back(w);
    exp_addr.push_back(32'(4 * wr_idx));
    wr_idx++;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    rx_i = 1'b1;
    gnt_i = 1'b0;
    en_i = 1'b1;
    exp_data.delete();
    exp_addr.delete();
    wr_idx = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    repeat (CPB) @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(posedge clk_i);
      #1;
    end
    rx_i = stop;
    repeat (CPB) @(posedge clk_i);
    #1 rx_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_data.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_data.size());
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({we_o, done_o, frame_err_o, overrun_o} !== 4'b0 || addr_o !== 32'h0 ||
        wdata_o !== 32'h0 || word_cnt_o !== 16'h0) begin
      errors++;
      $display("FAIL reset: we=%b done=%b ferr=%b ovr=%b addr=%h data=%h cnt=%0d, required all zero",
               we_o, done_o, frame_err_o, overrun_o, addr_o, wdata_o, word_cnt_o);
    end
  endtask

  task automatic test_single;
    int c0;
    do_reset();
    send_byte(8'h13, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h20, 1'b1);
    c0 = cyc;
    rise_cyc = -1;
    send_byte(8'h00, 1'b1);
    checks++;
    if (rise_cyc !== c0 + LAT) begin
      errors++;
      $display("FAIL single_latency: we rose at cycle %0d, required %0d", rise_cyc, c0 + LAT);
    end
    checks++;
    if (we_o !== 1'b1 || wdata_o !== 32'h00200113 || addr_o !== 32'h0) begin
      errors++;
      $display("FAIL single_present: we=%b data=%h addr=%h, required we=1 data=00200113 addr=0", we_o, wdata_o, addr_o);
    end
    expect_write(32'h00200113);
    gnt_i = 1'b1;
    @(posedge clk_i);
    #1 gnt_i = 1'b0;
    checks++;
    if (word_cnt_o !== 16'd1 || we_o !== 1'b0 || addr_o !== 32'h4) begin
      errors++;
      $display("FAIL single_grant: cnt=%0d we=%b addr=%h, required cnt=1 we=0 addr=4", word_cnt_o, we_o, addr_o);
    end
    check_drained("single");
  endtask

  task automatic test_back_to_back;
    logic [31:0] words[3] = '{32'h00000093, 32'h00100113, 32'h00208193};
    do_reset();
    gnt_i = 1'b1;
    foreach (words[i]) begin
      expect_write(words[i]);
      send_word(words[i]);
    end
    checks++;
    if (word_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL b2b_count: cnt=%0d, required 3", word_cnt_o);
    end
    check_drained("b2b");
  endtask

  task automatic test_end_word;
    do_reset();
    gnt_i = 1'b1;
    expect_write(32'h11223344);
    send_word(32'h11223344);
    expect_write(32'hA5A55A5A);
    send_word(32'hA5A55A5A);
    send_word(32'h00000FFF);
    checks++;
    if (done_o !== 1'b1 || word_cnt_o !== 16'd2 || we_o !== 1'b0) begin
      errors++;
      $display("FAIL end_done: done=%b cnt=%0d we=%b, required done=1 cnt=2 we=0", done_o, word_cnt_o, we_o);
    end
    send_word(32'hDEADBEEF);
    checks++;
    if (word_cnt_o !== 16'd2 || frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL end_ignore: cnt=%0d ferr=%b, required cnt=2 ferr=0", word_cnt_o, frame_err_o);
    end
    check_drained("end");
  endtask

  task automatic test_frame_err;
    do_reset();
    gnt_i = 1'b1;
    expect_write(32'h55443311);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    checks++;
    if (frame_err_o !== 1'b1) begin
      errors++;
      $display("FAIL ferr_flag: ferr=%b, required 1", frame_err_o);
    end
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    checks++;
    if (word_cnt_o !== 16'd1 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL ferr_count: cnt=%0d ovr=%b, required cnt=1 ovr=0", word_cnt_o, overrun_o);
    end
    check_drained("ferr");
  endtask

  task automatic test_glitch;
    do_reset();
    gnt_i = 1'b1;
    rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 rx_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    checks++;
    if ({we_o, done_o, frame_err_o, overrun_o} !== 4'b0 || word_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL glitch_flags: we=%b done=%b ferr=%b ovr=%b cnt=%0d, required all zero",
               we_o, done_o, frame_err_o, overrun_o, word_cnt_o);
    end
    expect_write(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    check_drained("glitch");
  endtask

  task automatic test_overrun_reset;
    do_reset();
    expect_write(32'h01234567);
    send_word(32'h01234567);
    send_word(32'h89ABCDEF);
    checks++;
    if (overrun_o !== 1'b1 || we_o !== 1'b1 || wdata_o !== 32'h01234567 || addr_o !== 32'h0) begin
      errors++;
      $display("FAIL overrun: ovr=%b we=%b data=%h addr=%h, required ovr=1 we=1 data=01234567 addr=0",
               overrun_o, we_o, wdata_o, addr_o);
    end
    rx_i = 1'b0;
    repeat (CPB + 5) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({we_o, done_o, frame_err_o, overrun_o} !== 4'b0 || addr_o !== 32'h0 ||
        wdata_o !== 32'h0 || word_cnt_o !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: we=%b done=%b ferr=%b ovr=%b addr=%h data=%h cnt=%0d, required all zero",
               we_o, done_o, frame_err_o, overrun_o, addr_o, wdata_o, word_cnt_o);
    end
    exp_data.delete();
    exp_addr.delete();
    rx_i = 1'b1;
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_end_word();
    test_frame_err();
    test_glitch();
    test_overrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
